if_fetch_queue: RTL and testbench

- Decoupling stage between the fetch stage (PC register plus clocked instruction memory) and the decode stage.
- The PC has no enable, so fetch never stalls. This block absorbs fetched (PcPlus4, instruction) pairs in a small FIFO and presents one pair per cycle to decode through the IF/ID output register.
- On overflow it drops the fetch and requests a PC replay through the existing branch/pc_branch path. It then discards stale fetches until the replayed address returns.

---
 rtl/if_fetch_queue_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/if_fetch_queue.sv | 75 +++++++
 tb/tb_if_fetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared widths, NOP encoding and replay FSM states for the fetch queue.
package if_fetch_queue_pkg;
  localparam int N = 31;
  localparam int XLEN = N + 1;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO; the count carries an extra bit so full and empty differ.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end
  assign dout  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: buffers non-stalling fetches for decode; on overflow drops the fetch,
// requests a PC replay and discards stale fetches until the replayed address returns.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int W = XLEN,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             PcPlus4_F,
  input  logic [W-1:0]             Instruction_F,
  input  logic                     stall_D,
  input  logic                     flush_D,
  output logic [W-1:0]             PcPlus4_D,
  output logic [W-1:0]             Instruction_D,
  output logic                     valid_D,
  output logic                     replay_F,
  output logic [W-1:0]             replay_pc_F,
  output logic [$clog2(DEPTH):0]   occupancy
);
  state_t state, state_nx;
  logic [W-1:0] tag;
  logic [2*W-1:0] head;
  logic full, empty, match, accept, pop, space, bypass, push, overflow;
  always_comb begin
    match    = PcPlus4_F == tag;
    accept   = !flush_D && (state == RUN || match);
    pop      = !flush_D && !stall_D && !empty;
    space    = !full || pop;
    bypass   = accept && !stall_D && empty;
    push     = accept && space && !bypass;
    overflow = accept && !space;
    state_nx = flush_D ? RUN : overflow ? DRAIN : accept ? RUN : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      tag   <= '0;
    end else begin
      state <= state_nx;
      if (overflow) tag <= PcPlus4_F;
    end
  end
  assign replay_F    = overflow;
  assign replay_pc_F = overflow ? PcPlus4_F - W'(4) : '0;
  // IF/ID register: FIFO head has priority; bypass only when the FIFO is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PcPlus4_D     <= '0;
      Instruction_D <= W'(NOP);
      valid_D       <= 1'b0;
    end else if (flush_D) begin
      PcPlus4_D     <= '0;
      Instruction_D <= W'(NOP);
      valid_D       <= 1'b0;
    end else if (!stall_D) begin
      valid_D       <= pop || bypass;
      PcPlus4_D     <= pop ? head[2*W-1:W] : bypass ? PcPlus4_F : PcPlus4_D;
      Instruction_D <= pop ? head[W-1:0] : bypass ? Instruction_F : W'(NOP);
    end
  end
  fetch_fifo #(.WIDTH(2*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_D),
    .push  (push),
    .pop   (pop),
    .din   ({PcPlus4_F, Instruction_F}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed scenarios for the fetch queue with hand-computed expectations.
module tb_if_fetch_queue;
  logic        clk, rst, stall_D, flush_D;
  logic [31:0] PcPlus4_F, Instruction_F, PcPlus4_D, Instruction_D, replay_pc_F;
  logic        valid_D, replay_F;
  logic [2:0]  occupancy;
  int passed = 0;
  int total = 0;

  if_fetch_queue #(.W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .PcPlus4_F(PcPlus4_F), .Instruction_F(Instruction_F),
    .stall_D(stall_D), .flush_D(flush_D), .PcPlus4_D(PcPlus4_D),
    .Instruction_D(Instruction_D), .valid_D(valid_D), .replay_F(replay_F),
    .replay_pc_F(replay_pc_F), .occupancy(occupancy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] ins(input logic [31:0] p);
    return p * 3 + 32'h13;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic s, input logic f);
    PcPlus4_F = pc;
    Instruction_F = ins(pc);
    stall_D = s;
    flush_D = f;
  endtask

  task automatic do_reset();
    rst = 0;
    drive(32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1;
  endtask

  task automatic expect_d(input string name, input logic [31:0] pc, input logic v, input logic [2:0] occ);
    total++;
    if ({PcPlus4_D, Instruction_D, valid_D, occupancy} !== {pc, v ? ins(pc) : 32'h0, v, occ})
      $display("FAIL %s: got pc=%h ins=%h v=%b occ=%0d, want pc=%h ins=%h v=%b occ=%0d", name,
               PcPlus4_D, Instruction_D, valid_D, occupancy, pc, v ? ins(pc) : 32'h0, v, occ);
    else passed++;
  endtask

  task automatic expect_replay(input string name, input logic r, input logic [31:0] rpc);
    #1;
    total++;
    if ({replay_F, replay_pc_F} !== {r, rpc})
      $display("FAIL %s: got replay=%b pc=%h, want replay=%b pc=%h", name, replay_F, replay_pc_F, r, rpc);
    else passed++;
  endtask

  task automatic fill_full();
    drive(32'h4, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(32'h8 + 32'(i) * 4, 1, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 0;
    drive(32'h44, 0, 0);
    #1;
    total++;
    if ({PcPlus4_D, Instruction_D, valid_D, replay_F, replay_pc_F, occupancy} !== '0)
      $display("FAIL reset_state: got pc=%h ins=%h v=%b r=%b rpc=%h occ=%0d, want all 0",
               PcPlus4_D, Instruction_D, valid_D, replay_F, replay_pc_F, occupancy);
    else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(32'(i) * 4, 0, 0);
      tick();
      expect_d("stream", 32'(i) * 4, 1, 0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(32'h4, 0, 0); tick();
    for (int i = 1; i <= 3; i++) begin
      drive(32'h4 + 32'(i) * 4, 1, 0);
      tick();
      expect_d("stall_fill", 32'h4, 1, 3'(i));
    end
    for (int i = 0; i < 4; i++) begin
      drive(32'h14 + 32'(i) * 4, 0, 0);
      tick();
      expect_d("stall_release", 32'h8 + 32'(i) * 4, 1, 3);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(32'(i) * 4, 0, 0); tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(32'h14 + 32'(i) * 4, 1, 0); tick();
    end
    expect_d("ovf_full", 32'h10, 1, 4);
    drive(32'h24, 1, 0);
    expect_replay("ovf_replay", 1, 32'h20);
    tick();
    expect_d("ovf_dropped", 32'h10, 1, 4);
    drive(32'h28, 1, 0);
    expect_replay("drain_stale28", 0, 32'h0);
    tick();
    drive(32'h2C, 1, 0);
    expect_replay("drain_stale2c", 0, 32'h0);
    tick();
    expect_d("drain_hold", 32'h10, 1, 4);
    drive(32'h24, 1, 0);
    expect_replay("drain_rereplay", 1, 32'h20);
    tick();
    drive(32'h24, 0, 0);
    expect_replay("simul_no_replay", 0, 32'h0);
    tick();
    expect_d("simul_occ4", 32'h14, 1, 4);
    for (int i = 0; i < 5; i++) begin
      drive(32'h28 + 32'(i) * 4, 0, 0);
      tick();
      expect_d("replay_order", 32'h18 + 32'(i) * 4, 1, 4);
    end
  endtask

  task automatic test_flush();
    do_reset();
    fill_full();
    drive(32'h18, 1, 0); tick();
    drive(32'h30, 0, 0);
    expect_replay("flush_prep_stale", 0, 32'h0);
    tick();
    expect_d("flush_prep", 32'h8, 1, 3);
    drive(32'h18, 1, 1);
    expect_replay("flush_no_replay", 0, 32'h0);
    tick();
    expect_d("flush_clear", 32'h0, 0, 0);
    drive(32'h100, 0, 0); tick();
    expect_d("flush_run", 32'h100, 1, 0);
    do_reset();
    fill_full();
    drive(32'h18, 1, 1);
    expect_replay("flush_over_ovf", 0, 32'h0);
    tick();
    expect_d("flush_over_ovf_clear", 32'h0, 0, 0);
  endtask

  task automatic test_reset_drain();
    do_reset();
    fill_full();
    drive(32'h18, 1, 0); tick();
    drive(32'h40, 1, 0);
    #2;
    rst = 0;
    #1;
    total++;
    if ({PcPlus4_D, Instruction_D, valid_D, replay_F, replay_pc_F, occupancy} !== '0)
      $display("FAIL reset_drain_async: got pc=%h ins=%h v=%b r=%b rpc=%h occ=%0d, want all 0",
               PcPlus4_D, Instruction_D, valid_D, replay_F, replay_pc_F, occupancy);
    else passed++;
    tick();
    #3;
    rst = 1;
    drive(32'h4, 0, 0); tick();
    expect_d("reset_drain_resume", 32'h4, 1, 0);
    drive(32'h8, 0, 0); tick();
    expect_d("reset_drain_resume2", 32'h8, 1, 0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_overflow();
    test_flush();
    test_reset_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
